pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised elastic pipeline register chain that replaces hand-written per-stage latch bundles between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload through DEPTH register stages under a valid/ready handshake. It supports synchronous flush with a zeroed payload (instruction 0 is a nop), backpressure with bubble collapsing, and an optional skid buffer that registers the upstream ready. It also exports occupancy and a saturating stall counter for performance debug.

## Interface
- WIDTH, 64, payload bits per entry (≥1)
- DEPTH, 1, number of register stages (≥1)
- SKID, 0, 1 adds a one-entry skid buffer and makes in_ready a register output
- CW, $clog2(DEPTH+2), occupancy width (derived, not overridden)
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- flush  in  1  discard all held entries this edge
- in_valid  in  1  upstream entry present
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  chain accepts in_data this cycle
- out_valid  out  1  last stage holds an entry
- out_data  out  WIDTH  last-stage payload
- out_ready  in  1  downstream consumes out_data this cycle
- occupancy  out  CW  registered count of valid entries (stages + skid)
- stall_cnt  out  32  saturating count of cycles with out_valid & ~out_ready

## Operation
- State: stages s[0..DEPTH-1], each a valid bit v[i] and data d[i]. s[DEPTH-1] drives out_valid/out_data. Skid entry sv/sd exists only when SKID=1.
- Advance: adv[DEPTH-1] = out_ready | ~v[DEPTH-1]; adv[i] = adv[i+1] | ~v[i] (combinational; bubbles collapse).
- Stage i with adv[i] loads v/d from stage i-1. Stage 0 loads from its source. A stage without adv holds.
- SKID=0: in_ready = adv[0]; stage 0 source = in_valid/in_data.
- SKID=1: in_ready = ~sv (register only, no combinational path from out_ready). Stage 0 source = skid when sv, else input.
  - Input handshake with ~adv[0] and ~sv writes the skid entry.
  - sv & adv[0] drains the skid entry into s[0]. in_ready is 0 that cycle, so no input is taken.
- Flush (priority over every load):
  - All v[i] and sv clear to 0; all d[i] and sd clear to 0.
  - An input handshake in the flush cycle is accepted and dropped.
  - An output handshake in the flush cycle completes normally.
- occupancy next = popcount(next v) + next sv. Never exceeds DEPTH+SKID.
- stall_cnt increments when out_valid & ~out_ready and holds at 32'hFFFF_FFFF. Flush does not clear it; only reset does.

## Timing
- Reset (nRST low at an edge): v, sv, d, sd, occupancy, stall_cnt all 0.
  - out_valid=0 and out_data=0 from the next cycle.
  - in_ready=1 after reset for both SKID values.
- Reset mid-transfer drops all entries; no partial payload survives.
- Latency: an entry accepted at edge k appears at out_valid after edge k+DEPTH-1 (visible in cycle k+DEPTH) with no backpressure. A trip through the skid entry adds 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- SKID=1 sustained backpressure: after the skid entry fills, in_ready drops for one cycle per drain.
- Full: all v=1 (and sv=1 when SKID=1) with out_ready=0 gives in_ready=0. Nothing is overwritten.
- Full with out_ready=1 (SKID=0): the whole chain shifts; in_ready=1 in the same cycle.
- Empty: out_valid=0, out_data=0 after flush or reset. out_data is don't-care only while out_valid=0 after normal drain (it keeps the last value).
- flush and nRST both low: reset behaviour.
- in_data must be stable while in_valid & ~in_ready. out_data is stable while out_valid & ~out_ready.

## Test plan
- Reset, DEPTH=3, SKID=0: stream in_data 1..8 with out_ready=1 → out_data 1..8 on consecutive cycles, first in cycle 3; occupancy steady at 3; stall_cnt=0.
- DEPTH=2, SKID=0: hold out_ready=0 and offer 5 entries → 2 accepted, in_ready=0, occupancy=2, stall_cnt increments once per cycle.
  - Then raise out_ready → entries exit in order with no loss or duplicate.
- DEPTH=2, SKID=1: apply backpressure on the edge an entry arrives → the entry lands in the skid entry and occupancy=3. in_ready shows no same-cycle dependence on out_ready.
  - Release out_ready → order preserved.
- Full chain with payload 32'hDEAD_BEEF plus flush=1 with in_valid=1 → next cycle out_valid=0, out_data=0, occupancy=0. The flushed input never appears.
- Force stall_cnt to 32'hFFFF_FFFE and hold stall for 3 cycles → saturates at 32'hFFFF_FFFF.
- Drop nRST mid-stream for one edge → all outputs 0 next cycle and in_ready=1. Stream restarts cleanly.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic register chain for carrying an opaque payload between CPU pipeline
//   stages under a valid/ready handshake. Bubbles collapse under backpressure.
//   Flush empties the chain and zeroes every payload (all-zero is a nop).
//   An optional one-entry skid buffer makes in_ready a pure register output.
//
// Ports
//   CLK        in   clock, all state on rising edge
//   nRST       in   synchronous active-low reset
//   flush      in   discard all held entries this edge
//   in_valid   in   upstream entry present
//   in_data    in   upstream payload [WIDTH]
//   in_ready   out  chain accepts in_data this cycle
//   out_valid  out  last stage holds an entry
//   out_data   out  last-stage payload [WIDTH]
//   out_ready  in   downstream consumes out_data this cycle
//   occupancy  out  registered count of held entries (stages + skid) [CW]
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready

module pipe_stage_chain #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1,
   parameter int SKID  = 0,
   localparam int CW   = $clog2(DEPTH + 2)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    occupancy,
   output logic [31:0]      stall_cnt
);

   logic [DEPTH-1:0] r_v;
   logic [WIDTH-1:0] r_d [DEPTH];
   logic             r_sv;
   logic [WIDTH-1:0] r_sd;
   logic [CW-1:0]    r_occ;
   logic [31:0]      r_stall_cnt;

   logic [DEPTH-1:0] w_adv;
   logic             w_carry;
   logic [DEPTH-1:0] w_v_nxt;
   logic [WIDTH-1:0] w_d_nxt [DEPTH];
   logic             w_sv_nxt;
   logic [WIDTH-1:0] w_sd_nxt;
   logic [CW-1:0]    w_occ_nxt;
   logic             w_skid_on;
   logic             w_src_v;
   logic [WIDTH-1:0] w_src_d;
   logic             w_in_hs;

   assign w_skid_on = (SKID != 0);

   // A stage may advance when everything downstream of it advances or it is
   // itself empty; this is what lets bubbles collapse under backpressure.
   always_comb begin
      w_carry = out_ready;
      w_adv   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_carry  = w_carry | ~r_v[i];
         w_adv[i] = w_carry;
      end
   end

   // With the skid buffer, in_ready depends only on the skid register so no
   // combinational path runs from out_ready back upstream.
   assign in_ready = w_skid_on ? ~r_sv : w_adv[0];
   assign w_in_hs  = in_valid & in_ready;
   assign w_src_v  = (w_skid_on && r_sv) ? 1'b1 : in_valid;
   assign w_src_d  = (w_skid_on && r_sv) ? r_sd : in_data;

   always_comb begin
      w_v_nxt  = r_v;
      w_d_nxt  = r_d;
      w_sv_nxt = r_sv;
      w_sd_nxt = r_sd;

      // Payload only moves with a valid entry, so an empty last stage keeps
      // its last value (or zero after flush/reset) instead of picking up
      // whatever is sitting on in_data.
      if (w_adv[0]) begin
         w_v_nxt[0] = w_src_v;
         if (w_src_v) begin
            w_d_nxt[0] = w_src_d;
         end
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (w_adv[i]) begin
            w_v_nxt[i] = r_v[i-1];
            if (r_v[i-1]) begin
               w_d_nxt[i] = r_d[i-1];
            end
         end
      end

      if (w_skid_on) begin
         if (r_sv && w_adv[0]) begin
            w_sv_nxt = 1'b0;
         end else if (w_in_hs && !w_adv[0]) begin
            w_sv_nxt = 1'b1;
            w_sd_nxt = in_data;
         end
      end

      if (flush) begin
         w_v_nxt  = '0;
         w_sv_nxt = 1'b0;
         w_sd_nxt = '0;
         for (int i = 0; i < DEPTH; i++) begin
            w_d_nxt[i] = '0;
         end
      end

      w_occ_nxt = CW'(w_sv_nxt);
      for (int i = 0; i < DEPTH; i++) begin
         w_occ_nxt = w_occ_nxt + CW'(w_v_nxt[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_v         <= '0;
         r_sv        <= 1'b0;
         r_sd        <= '0;
         r_occ       <= '0;
         r_stall_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_d[i] <= '0;
         end
      end else begin
         r_v   <= w_v_nxt;
         r_d   <= w_d_nxt;
         r_sv  <= w_sv_nxt;
         r_sd  <= w_sd_nxt;
         r_occ <= w_occ_nxt;
         // Flush deliberately leaves the stall counter alone.
         if (r_v[DEPTH-1] && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign out_valid = r_v[DEPTH-1];
   assign out_data  = r_d[DEPTH-1];
   assign occupancy = r_occ;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain
//   Three chains side by side: u0 (DEPTH=3, SKID=0), u1 (DEPTH=2, SKID=0),
//   u2 (DEPTH=2, SKID=1), all 32-bit payload. An entry-list model (each held
//   entry with its position, skid = -1) predicts every output each cycle;
//   directed literal checks pin the model at the interesting points.

module tb_pipe_stage_chain;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic [2:0]       nrst, flsh, iv, ordy;
   logic [2:0]       irdy, ov;
   logic [2:0][31:0] idat, od, st;
   logic [2:0]       occ0;
   logic [1:0]       occ1, occ2;

   pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .SKID(0)) u0 (
      .CLK(clk), .nRST(nrst[0]), .flush(flsh[0]), .in_valid(iv[0]), .in_data(idat[0]),
      .in_ready(irdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
      .occupancy(occ0), .stall_cnt(st[0]));
   pipe_stage_chain #(.WIDTH(32), .DEPTH(2), .SKID(0)) u1 (
      .CLK(clk), .nRST(nrst[1]), .flush(flsh[1]), .in_valid(iv[1]), .in_data(idat[1]),
      .in_ready(irdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
      .occupancy(occ1), .stall_cnt(st[1]));
   pipe_stage_chain #(.WIDTH(32), .DEPTH(2), .SKID(1)) u2 (
      .CLK(clk), .nRST(nrst[2]), .flush(flsh[2]), .in_valid(iv[2]), .in_data(idat[2]),
      .in_ready(irdy[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2]),
      .occupancy(occ2), .stall_cnt(st[2]));

   int checks = 0;
   int errors = 0;

   // Model: ordered list of held entries, oldest first, with stage position.
   int          mpos [3][4];
   logic [31:0] mdat [3][4];
   int          mcnt [3];
   logic [31:0] mst  [3];
   bit          mzero[3];

   function automatic int dep(input int i);
      return (i == 0) ? 3 : 2;
   endfunction

   function automatic int skd(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic bit p_ov(input int i);
      return (mcnt[i] > 0) && (mpos[i][0] == dep(i) - 1);
   endfunction

   function automatic bit p_ir(input int i);
      if (skd(i) == 1) return mcnt[i] != dep(i) + 1;
      return !((mcnt[i] == dep(i)) && !ordy[i]);
   endfunction

   function automatic int occ_act(input int i);
      if (i == 0) return int'(occ0);
      if (i == 1) return int'(occ1);
      return int'(occ2);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic mstep(input int i);
      bit          ohs, ihs;
      int          np[4];
      logic [31:0] nd[4];
      int          nc, pn, p;
      if (!nrst[i]) begin
         mcnt[i] = 0; mst[i] = 32'd0; mzero[i] = 1'b1;
         return;
      end
      ohs = p_ov(i) && ordy[i];
      ihs = iv[i] && p_ir(i);
      if (p_ov(i) && !ordy[i] && mst[i] != 32'hFFFF_FFFF) mst[i] = mst[i] + 32'd1;
      if (flsh[i]) begin
         mcnt[i] = 0; mzero[i] = 1'b1;
         return;
      end
      if (ihs) begin
         mpos[i][mcnt[i]] = -1;
         mdat[i][mcnt[i]] = idat[i];
         mcnt[i]++;
      end
      // Each entry moves forward one slot unless the slot ahead stays taken.
      nc = 0;
      pn = dep(i);
      for (int k = 0; k < mcnt[i]; k++) begin
         p = mpos[i][k];
         if (k == 0 && p == dep(i) - 1 && ohs) continue;
         if (p + 1 < pn) p++;
         np[nc] = p; nd[nc] = mdat[i][k]; nc++;
         pn = p;
      end
      for (int k = 0; k < nc; k++) begin
         mpos[i][k] = np[k]; mdat[i][k] = nd[k];
      end
      mcnt[i] = nc;
      if (nc > 0 && np[0] == dep(i) - 1) mzero[i] = 1'b0;
   endtask

   task automatic cycle_check();
      for (int i = 0; i < 3; i++) begin
         if (p_ov(i)) chk($sformatf("u%0d out_data", i), od[i], mdat[i][0]);
         else if (mzero[i]) chk($sformatf("u%0d out_data empty", i), od[i], 32'd0);
         chk($sformatf("u%0d out_valid", i), {31'd0, ov[i]}, {31'd0, p_ov(i)});
         chk($sformatf("u%0d in_ready", i), {31'd0, irdy[i]}, {31'd0, p_ir(i)});
         chk($sformatf("u%0d occupancy", i), occ_act(i), mcnt[i]);
         chk($sformatf("u%0d stall_cnt", i), st[i], mst[i]);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         cycle_check();
         for (int i = 0; i < 3; i++) mstep(i);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         mcnt[i] = 0; mst[i] = 32'd0; mzero[i] = 1'b1;
      end
      nrst = '0; flsh = '0; iv = '0; ordy = '0; idat = '0;
      @(posedge clk);
      #1;
      nrst = 3'b111;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d reset out_valid", i), {31'd0, ov[i]}, 32'd0);
         chk($sformatf("u%0d reset out_data", i), od[i], 32'd0);
         chk($sformatf("u%0d reset occupancy", i), occ_act(i), 32'd0);
         chk($sformatf("u%0d reset stall_cnt", i), st[i], 32'd0);
         chk($sformatf("u%0d reset in_ready", i), {31'd0, irdy[i]}, 32'd1);
      end

      // u0: stream 1..8 with out_ready held high
      ordy[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         iv[0]   = (k < 8);
         idat[0] = 32'(k + 1);
         tick(1);
         if (k >= 2) begin
            chk("stream out_valid", {31'd0, ov[0]}, 32'd1);
            chk("stream out_data", od[0], 32'(k - 1));
         end
         if (k >= 2 && k <= 7) chk("stream occupancy", occ_act(0), 32'd3);
      end
      iv[0] = 1'b0;
      tick(2);
      chk("stream stall_cnt", st[0], 32'd0);

      // u1: backpressure, then release
      ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 32'h11;
      tick(1);
      idat[1] = 32'h12;
      tick(1);
      chk("bp occupancy", occ_act(1), 32'd2);
      chk("bp in_ready", {31'd0, irdy[1]}, 32'd0);
      idat[1] = 32'h13;
      tick(3);
      chk("bp in_ready held", {31'd0, irdy[1]}, 32'd0);
      chk("bp occupancy held", occ_act(1), 32'd2);
      chk("bp stall_cnt", st[1], 32'd3);
      ordy[1] = 1'b1;
      tick(1);
      chk("bp release out_data", od[1], 32'h12);
      idat[1] = 32'h14;
      tick(1);
      idat[1] = 32'h15;
      tick(1);
      chk("bp order out_data", od[1], 32'h14);
      iv[1] = 1'b0;
      tick(4);

      // u2: entry lands in skid under backpressure
      ordy[2] = 1'b1; iv[2] = 1'b1; idat[2] = 32'hA1;
      tick(1);
      idat[2] = 32'hA2;
      tick(1);
      ordy[2] = 1'b0; idat[2] = 32'hA3;
      tick(1);
      chk("skid occupancy", occ_act(2), 32'd3);
      chk("skid in_ready", {31'd0, irdy[2]}, 32'd0);
      chk("skid out_data", od[2], 32'hA1);
      ordy[2] = 1'b1;
      #1;
      chk("skid in_ready vs out_ready=1", {31'd0, irdy[2]}, 32'd0);
      ordy[2] = 1'b0;
      #1;
      chk("skid in_ready vs out_ready=0", {31'd0, irdy[2]}, 32'd0);
      idat[2] = 32'hA4;
      tick(1);
      ordy[2] = 1'b1;
      tick(1);
      chk("skid drain in_ready", {31'd0, irdy[2]}, 32'd1);
      chk("skid drain out_data", od[2], 32'hA2);
      chk("skid drain occupancy", occ_act(2), 32'd2);
      tick(1);
      chk("skid order out_data", od[2], 32'hA3);
      iv[2] = 1'b0;
      tick(4);

      // u0: fill with DEADBEEF, flush with an input handshake pending
      ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 32'hDEAD_BEEF;
      tick(3);
      chk("full occupancy", occ_act(0), 32'd3);
      chk("full in_ready", {31'd0, irdy[0]}, 32'd0);
      chk("full out_data", od[0], 32'hDEAD_BEEF);
      flsh[0] = 1'b1; ordy[0] = 1'b1; idat[0] = 32'hCAFE_F00D;
      tick(1);
      chk("flush out_valid", {31'd0, ov[0]}, 32'd0);
      chk("flush out_data", od[0], 32'd0);
      chk("flush occupancy", occ_act(0), 32'd0);
      flsh[0] = 1'b0; iv[0] = 1'b0;
      tick(4);
      chk("flush no ghost", {31'd0, ov[0]}, 32'd0);

      // u1: stall counter saturation
      ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 32'h77;
      tick(1);
      iv[1] = 1'b0;
      tick(1);
      force u1.r_stall_cnt = 32'hFFFF_FFFE;
      #1;
      release u1.r_stall_cnt;
      mst[1] = 32'hFFFF_FFFE;
      tick(3);
      chk("stall saturate", st[1], 32'hFFFF_FFFF);
      ordy[1] = 1'b1;
      tick(2);

      // u0: reset mid-stream
      ordy[0] = 1'b1; iv[0] = 1'b1; idat[0] = 32'h100;
      tick(1);
      idat[0] = 32'h101;
      tick(1);
      nrst[0] = 1'b0; idat[0] = 32'h102;
      tick(1);
      chk("rst out_valid", {31'd0, ov[0]}, 32'd0);
      chk("rst out_data", od[0], 32'd0);
      chk("rst occupancy", occ_act(0), 32'd0);
      chk("rst stall_cnt", st[0], 32'd0);
      chk("rst in_ready", {31'd0, irdy[0]}, 32'd1);
      nrst[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         idat[0] = 32'h200 + 32'(k);
         tick(1);
      end
      chk("restart out_data", od[0], 32'h200);
      iv[0] = 1'b0;
      tick(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
